// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one 8-bit ALU between the execute pipeline (req 0) and the
// address-generation path (req 1); holds operands for EXEC_CYCLES, then returns the result.
module alu_share_arb #(
   parameter int unsigned EXEC_CYCLES = 1
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_req0,
   input  logic [4:0] i_op0,
   input  logic [7:0] i_a0,
   input  logic [7:0] i_b0,
   input  logic [7:0] i_c0,
   input  logic [3:0] i_reg_num0,
   input  logic       i_req1,
   input  logic [4:0] i_op1,
   input  logic [7:0] i_a1,
   input  logic [7:0] i_b1,
   input  logic [7:0] i_c1,
   input  logic [3:0] i_reg_num1,
   output logic       o_gnt0,
   output logic       o_gnt1,
   output logic       o_done0,
   output logic       o_done1,
   output logic [7:0] o_result,
   output logic [3:0] o_result_reg,
   output logic       o_flag,
   output logic       o_busy,
   output logic [4:0] o_alu_op,
   output logic [7:0] o_alu_a,
   output logic [7:0] o_alu_b,
   output logic [7:0] o_alu_c,
   output logic [3:0] o_alu_reg_num,
   output logic       o_alu_c_in,
   input  logic [7:0] i_alu_out,
   input  logic       i_alu_flag_out
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StExec = 2'd1;
   localparam logic [1:0] StWb   = 2'd2;

   localparam logic [3:0] CntInit = 4'(EXEC_CYCLES - 1);

   logic [1:0] r_state;
   logic       r_owner;
   logic       r_last;
   logic [3:0] r_cnt;
   logic [7:0] r_result;
   logic [3:0] r_result_reg;
   logic       r_flag;
   logic [4:0] r_alu_op;
   logic [7:0] r_alu_a;
   logic [7:0] r_alu_b;
   logic [7:0] r_alu_c;
   logic [3:0] r_alu_reg_num;

   logic w_idle;
   logic w_pick1;
   logic w_gnt0;
   logic w_gnt1;

   // On a tie the requester that did not win last time is served.
   assign w_idle  = (r_state == StIdle);
   assign w_pick1 = i_req1 & (~i_req0 | ~r_last);
   assign w_gnt1  = w_idle & w_pick1;
   assign w_gnt0  = w_idle & i_req0 & ~w_pick1;

   // Grants are combinational in IDLE; mask them while reset is held so nothing leaks out.
   assign o_gnt0 = w_gnt0 & i_reset_n;
   assign o_gnt1 = w_gnt1 & i_reset_n;

   assign o_done0       = (r_state == StWb) & ~r_owner;
   assign o_done1       = (r_state == StWb) & r_owner;
   assign o_busy        = ~w_idle;
   assign o_result      = r_result;
   assign o_result_reg  = r_result_reg;
   assign o_flag        = r_flag;
   assign o_alu_op      = r_alu_op;
   assign o_alu_a       = r_alu_a;
   assign o_alu_b       = r_alu_b;
   assign o_alu_c       = r_alu_c;
   assign o_alu_reg_num = r_alu_reg_num;
   assign o_alu_c_in    = ~r_owner & r_flag;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state       <= StIdle;
         r_owner       <= 1'b0;
         r_last        <= 1'b1;
         r_cnt         <= 4'd0;
         r_result      <= 8'd0;
         r_result_reg  <= 4'd0;
         r_flag        <= 1'b0;
         r_alu_op      <= 5'd0;
         r_alu_a       <= 8'd0;
         r_alu_b       <= 8'd0;
         r_alu_c       <= 8'd0;
         r_alu_reg_num <= 4'd0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_gnt0 || w_gnt1) begin
                  r_owner       <= w_gnt1;
                  r_last        <= w_gnt1;
                  r_alu_op      <= w_gnt1 ? i_op1      : i_op0;
                  r_alu_a       <= w_gnt1 ? i_a1       : i_a0;
                  r_alu_b       <= w_gnt1 ? i_b1       : i_b0;
                  r_alu_c       <= w_gnt1 ? i_c1       : i_c0;
                  r_alu_reg_num <= w_gnt1 ? i_reg_num1 : i_reg_num0;
                  r_cnt         <= CntInit;
                  r_state       <= StExec;
               end
            end
            StExec: begin
               if (r_cnt == 4'd0) begin
                  r_result     <= i_alu_out;
                  r_result_reg <= r_alu_reg_num;
                  // Only the execute pipeline owns the architectural flag.
                  if (!r_owner) begin
                     r_flag <= i_alu_flag_out;
                  end
                  r_state <= StWb;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            StWb: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: one instance with EXEC_CYCLES=1, one with EXEC_CYCLES=4,
// each wired to a small adder model standing in for the ALU.
module tb_alu_share_arb;

   localparam logic [4:0] OpAdd = 5'd1;

   logic       clk;
   logic       rst_n;
   logic       req0, req1;
   logic [4:0] op0, op1;
   logic [7:0] a0, b0, c0, a1, b1, c1;
   logic [3:0] rn0, rn1;

   logic       d1_gnt0, d1_gnt1, d1_done0, d1_done1, d1_flag, d1_busy, d1_c_in, d1_alu_flag;
   logic [7:0] d1_result, d1_alu_a, d1_alu_b, d1_alu_c, d1_alu_out;
   logic [3:0] d1_result_reg, d1_alu_rn;
   logic [4:0] d1_alu_op;

   logic       d4_gnt0, d4_gnt1, d4_done0, d4_done1, d4_flag, d4_busy, d4_c_in, d4_alu_flag;
   logic [7:0] d4_result, d4_alu_a, d4_alu_b, d4_alu_c, d4_alu_out;
   logic [3:0] d4_result_reg, d4_alu_rn;
   logic [4:0] d4_alu_op;

   int errors = 0;
   int checks = 0;

   // ALU stand-in: 8-bit add with carry-in, carry-out on FLAG_OUT.
   assign {d1_alu_flag, d1_alu_out} = {1'b0, d1_alu_a} + {1'b0, d1_alu_b} + {8'd0, d1_c_in};
   assign {d4_alu_flag, d4_alu_out} = {1'b0, d4_alu_a} + {1'b0, d4_alu_b} + {8'd0, d4_c_in};

   alu_share_arb #(.EXEC_CYCLES(1)) u_dut1 (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_req0(req0), .i_op0(op0), .i_a0(a0), .i_b0(b0), .i_c0(c0), .i_reg_num0(rn0),
      .i_req1(req1), .i_op1(op1), .i_a1(a1), .i_b1(b1), .i_c1(c1), .i_reg_num1(rn1),
      .o_gnt0(d1_gnt0), .o_gnt1(d1_gnt1), .o_done0(d1_done0), .o_done1(d1_done1),
      .o_result(d1_result), .o_result_reg(d1_result_reg), .o_flag(d1_flag), .o_busy(d1_busy),
      .o_alu_op(d1_alu_op), .o_alu_a(d1_alu_a), .o_alu_b(d1_alu_b), .o_alu_c(d1_alu_c),
      .o_alu_reg_num(d1_alu_rn), .o_alu_c_in(d1_c_in),
      .i_alu_out(d1_alu_out), .i_alu_flag_out(d1_alu_flag)
   );

   alu_share_arb #(.EXEC_CYCLES(4)) u_dut4 (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_req0(req0), .i_op0(op0), .i_a0(a0), .i_b0(b0), .i_c0(c0), .i_reg_num0(rn0),
      .i_req1(req1), .i_op1(op1), .i_a1(a1), .i_b1(b1), .i_c1(c1), .i_reg_num1(rn1),
      .o_gnt0(d4_gnt0), .o_gnt1(d4_gnt1), .o_done0(d4_done0), .o_done1(d4_done1),
      .o_result(d4_result), .o_result_reg(d4_result_reg), .o_flag(d4_flag), .o_busy(d4_busy),
      .o_alu_op(d4_alu_op), .o_alu_a(d4_alu_a), .o_alu_b(d4_alu_b), .o_alu_c(d4_alu_c),
      .o_alu_reg_num(d4_alu_rn), .o_alu_c_in(d4_c_in),
      .i_alu_out(d4_alu_out), .i_alu_flag_out(d4_alu_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic [7:0] a, input logic [7:0] b, input logic [3:0] rn);
      req0 = 1'b1; op0 = OpAdd; a0 = a; b0 = b; c0 = 8'h40; rn0 = rn;
   endtask

   task automatic drive1(input logic [7:0] a, input logic [7:0] b, input logic [3:0] rn);
      req1 = 1'b1; op1 = OpAdd; a1 = a; b1 = b; c1 = 8'h80; rn1 = rn;
   endtask

   task automatic do_reset();
      req0 = 1'b0; req1 = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      logic [59:0] v1, v4;
      req0 = 1'b0; req1 = 1'b0;
      rst_n = 1'b0;
      #1;
      v1 = {d1_gnt0, d1_gnt1, d1_done0, d1_done1, d1_result, d1_result_reg, d1_flag, d1_busy,
            d1_alu_op, d1_alu_a, d1_alu_b, d1_alu_c, d1_alu_rn, d1_c_in};
      v4 = {d4_gnt0, d4_gnt1, d4_done0, d4_done1, d4_result, d4_result_reg, d4_flag, d4_busy,
            d4_alu_op, d4_alu_a, d4_alu_b, d4_alu_c, d4_alu_rn, d4_c_in};
      checks++;
      if (v1 !== 60'd0) begin
         errors++; $display("FAIL reset_outputs_dut1: got %h expected 0", v1);
      end
      checks++;
      if (v4 !== 60'd0) begin
         errors++; $display("FAIL reset_outputs_dut4: got %h expected 0", v4);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      do_reset();
      drive0(8'd1, 8'd2, 4'd5);
      #1;
      checks++;
      if ({d1_gnt0, d1_gnt1, d1_busy} !== 3'b100) begin
         errors++; $display("FAIL single_gnt: got gnt0/gnt1/busy=%b expected 100",
                            {d1_gnt0, d1_gnt1, d1_busy});
      end
      tick();
      req0 = 1'b0;
      checks++;
      if ({d1_gnt0, d1_busy, d1_done0, d1_alu_a, d1_alu_b, d1_alu_op, d1_alu_rn}
          !== {1'b0, 1'b1, 1'b0, 8'd1, 8'd2, OpAdd, 4'd5}) begin
         errors++; $display("FAIL single_exec: gnt0=%b busy=%b done0=%b a=%0d b=%0d op=%0d rn=%0d",
                            d1_gnt0, d1_busy, d1_done0, d1_alu_a, d1_alu_b, d1_alu_op, d1_alu_rn);
      end
      tick();
      checks++;
      if ({d1_done0, d1_done1, d1_result, d1_result_reg} !== {1'b1, 1'b0, 8'd3, 4'd5}) begin
         errors++; $display("FAIL single_done: done0=%b done1=%b result=%0d reg=%0d expected 1 0 3 5",
                            d1_done0, d1_done1, d1_result, d1_result_reg);
      end
      tick();
      checks++;
      if ({d1_done0, d1_done1, d1_busy, d1_result} !== {3'b000, 8'd3}) begin
         errors++; $display("FAIL single_after: done0=%b done1=%b busy=%b result=%0d expected 0 0 0 3",
                            d1_done0, d1_done1, d1_busy, d1_result);
      end
   endtask

   task automatic test_tie();
      logic [7:0] exp_res;
      logic [3:0] exp_rn;
      do_reset();
      drive0(8'd10, 8'd1, 4'd1);
      drive1(8'd20, 8'd2, 4'd2);
      #1;
      for (int k = 0; k < 3; k++) begin
         exp_res = (k % 2 == 0) ? 8'd11 : 8'd22;
         exp_rn  = (k % 2 == 0) ? 4'd1 : 4'd2;
         checks++;
         if ({d1_gnt0, d1_gnt1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL tie_gnt%0d: got gnt0/gnt1=%b expected %s",
                               k, {d1_gnt0, d1_gnt1}, (k % 2 == 0) ? "10" : "01");
         end
         tick();
         if (k == 2) begin
            req0 = 1'b0; req1 = 1'b0;
         end
         tick();
         checks++;
         if ({d1_done0, d1_done1, d1_result, d1_result_reg}
             !== {((k % 2 == 0) ? 2'b10 : 2'b01), exp_res, exp_rn}) begin
            errors++; $display("FAIL tie_done%0d: done0/done1=%b result=%0d reg=%0d expected %0d %0d",
                               k, {d1_done0, d1_done1}, d1_result, d1_result_reg, exp_res, exp_rn);
         end
         tick();
      end
      checks++;
      if ({d1_gnt0, d1_gnt1, d1_busy} !== 3'b000) begin
         errors++; $display("FAIL tie_idle: gnt0/gnt1/busy=%b expected 000",
                            {d1_gnt0, d1_gnt1, d1_busy});
      end
   endtask

   // Runs one op on dut1 from requester `who` and checks C_IN seen, RESULT and FLAG afterwards.
   task automatic flag_op(input logic who, input logic [7:0] a, input logic [7:0] b,
                          input logic exp_cin, input logic [7:0] exp_res, input logic exp_flag);
      if (who) drive1(a, b, 4'd3);
      else     drive0(a, b, 4'd4);
      #1;
      tick();
      req0 = 1'b0; req1 = 1'b0;
      checks++;
      if (d1_c_in !== exp_cin) begin
         errors++; $display("FAIL flag_cin_req%0d: got %b expected %b", who, d1_c_in, exp_cin);
      end
      tick();
      checks++;
      if ({d1_done0, d1_done1, d1_result, d1_flag} !== {~who, who, exp_res, exp_flag}) begin
         errors++; $display("FAIL flag_done_req%0d: done0/done1=%b result=%0d flag=%b expected %0d %b",
                            who, {d1_done0, d1_done1}, d1_result, d1_flag, exp_res, exp_flag);
      end
      tick();
   endtask

   task automatic test_flag();
      do_reset();
      flag_op(1'b1, 8'd200, 8'd100, 1'b0, 8'd44, 1'b0);
      flag_op(1'b0, 8'd200, 8'd100, 1'b0, 8'd44, 1'b1);
      flag_op(1'b1, 8'd1,   8'd2,   1'b0, 8'd3,  1'b1);
      flag_op(1'b0, 8'd1,   8'd2,   1'b1, 8'd4,  1'b0);
   endtask

   task automatic test_stability();
      int  n;
      bit  a_bad;
      do_reset();
      drive0(8'd3, 8'd2, 4'd7);
      #1;
      checks++;
      if (d4_gnt0 !== 1'b1) begin
         errors++; $display("FAIL stab_gnt: got %b expected 1", d4_gnt0);
      end
      n = 0;
      a_bad = 1'b0;
      tick();
      a0 = 8'd9;
      req0 = 1'b0;
      n = 1;
      while (d4_done0 !== 1'b1 && n < 20) begin
         if (d4_alu_a !== 8'd3) a_bad = 1'b1;
         tick();
         n++;
      end
      checks++;
      if (a_bad) begin
         errors++; $display("FAIL stab_alu_a: operand changed during EXEC, now %0d expected 3",
                            d4_alu_a);
      end
      checks++;
      if (n !== 5) begin
         errors++; $display("FAIL stab_latency: got %0d cycles expected 5", n);
      end
      checks++;
      if ({d4_result, d4_result_reg} !== {8'd5, 4'd7}) begin
         errors++; $display("FAIL stab_result: got %0d reg %0d expected 5 reg 7",
                            d4_result, d4_result_reg);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive0(8'd5, 8'd6, 4'd2);
      #1;
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({d1_gnt0, d1_done0, d1_busy, d1_alu_a, d1_result} !== 19'd0) begin
         errors++; $display("FAIL midreset_clear: gnt0=%b done0=%b busy=%b alu_a=%0d result=%0d",
                            d1_gnt0, d1_done0, d1_busy, d1_alu_a, d1_result);
      end
      tick();
      checks++;
      if (d1_done0 !== 1'b0) begin
         errors++; $display("FAIL midreset_nodone: got %b expected 0", d1_done0);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (d1_gnt0 !== 1'b1) begin
         errors++; $display("FAIL midreset_regrant: got %b expected 1", d1_gnt0);
      end
      tick();
      req0 = 1'b0;
      tick();
      checks++;
      if ({d1_done0, d1_result, d1_result_reg} !== {1'b1, 8'd11, 4'd2}) begin
         errors++; $display("FAIL midreset_done: done0=%b result=%0d reg=%0d expected 1 11 2",
                            d1_done0, d1_result, d1_result_reg);
      end
      tick();
   endtask

   task automatic test_withdraw();
      do_reset();
      drive0(8'd1, 8'd1, 4'd1);
      #1;
      tick();
      req0 = 1'b0;
      drive1(8'd7, 8'd7, 4'd9);
      #1;
      checks++;
      if ({d1_gnt1, d1_busy} !== 2'b01) begin
         errors++; $display("FAIL withdraw_busy: gnt1/busy=%b expected 01", {d1_gnt1, d1_busy});
      end
      tick();
      req1 = 1'b0;
      checks++;
      if ({d1_done0, d1_gnt1} !== 2'b10) begin
         errors++; $display("FAIL withdraw_done0: done0/gnt1=%b expected 10", {d1_done0, d1_gnt1});
      end
      tick();
      checks++;
      if ({d1_gnt1, d1_busy, d1_done1} !== 3'b000) begin
         errors++; $display("FAIL withdraw_idle: gnt1/busy/done1=%b expected 000",
                            {d1_gnt1, d1_busy, d1_done1});
      end
      tick();
      checks++;
      if ({d1_gnt1, d1_busy, d1_result} !== {2'b00, 8'd2}) begin
         errors++; $display("FAIL withdraw_quiet: gnt1/busy=%b result=%0d expected 00 2",
                            {d1_gnt1, d1_busy}, d1_result);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req0 = 1'b0; op0 = 5'd0; a0 = 8'd0; b0 = 8'd0; c0 = 8'd0; rn0 = 4'd0;
      req1 = 1'b0; op1 = 5'd0; a1 = 8'd0; b1 = 8'd0; c1 = 8'd0; rn1 = 4'd0;
      test_reset();
      test_single();
      test_tie();
      test_flag();
      test_stability();
      test_reset_mid();
      test_withdraw();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
Arbitrates the single 8-bit ALU between two requesters: requester 0 is the main execute pipeline, requester 1 is the address-generation path. Grants with round-robin fairness, latches operands, holds them stable on the ALU inputs for a programmable settle time, then captures OUT/FLAG_OUT and returns the result to the winning requester. Owns the architectural flag bit that feeds ALU C_IN.

Parameters:
EXEC_CYCLES, 1, cycles ALU inputs are held before result capture (1..15)

Ports:
CLK  in  1  system clock, all state on rising edge
RESET_N  in  1  asynchronous active-low reset
REQ0  in  1  requester 0 request; held with operands until GNT0
OP0  in  5  requester 0 ALU op code (definitions package encoding)
A0, B0, C0  in  8 each  requester 0 operands (dest value, immediate/second, address base)
REG_NUM0  in  4  requester 0 destination register tag
REQ1, OP1, A1, B1, C1, REG_NUM1  in  1/5/8/8/8/4  requester 1, same meaning
GNT0, GNT1  out  1  one-cycle pulse: operands captured this edge
DONE0, DONE1  out  1  one-cycle pulse: RESULT/RESULT_REG valid for that requester
RESULT  out  8  captured ALU OUT
RESULT_REG  out  4  tag of the completed op
FLAG  out  1  architectural flag register
BUSY  out  1  high in EXEC and WB
ALU_OP  out  5  to ALU OP
ALU_A, ALU_B, ALU_C  out  8 each  to ALU INPUT_A/B/C
ALU_REG_NUM  out  4  to ALU REG_NUM
ALU_C_IN  out  1  to ALU C_IN
ALU_OUT  in  8  from ALU OUT
ALU_FLAG_OUT  in  1  from ALU FLAG_OUT

Behaviour:
- Reset (async, RESET_N low): state IDLE; GNT*, DONE*, BUSY, FLAG = 0; RESULT, RESULT_REG, ALU_* = 0; counter = 0; LAST = 1 (requester 0 wins first tie). Reset mid-EXEC/WB aborts: no DONE issued, operation lost, requester must re-request.
- States: IDLE, EXEC, WB.
- IDLE: if no REQ, stay. If exactly one REQ, grant it. If both, grant requester != LAST. On grant: GNT pulse, latch OP/A/B/C/REG_NUM into ALU_* registers, record owner, LAST <= owner, counter <= EXEC_CYCLES-1, go EXEC.
- EXEC: ALU_* held constant. If counter == 0: RESULT <= ALU_OUT, RESULT_REG <= ALU_REG_NUM, go WB; else decrement.
- WB: DONE<owner> high exactly this cycle; go IDLE. No grant issued in WB.
- Latency: GNT edge to DONE high = EXEC_CYCLES+1 cycles; one op per EXEC_CYCLES+2 cycles at best.
- ALU_C_IN = FLAG when owner = 0, 0 when owner = 1 (combinational from registered owner/FLAG).
- FLAG updated only at EXEC capture with owner 0: FLAG <= ALU_FLAG_OUT. Requester-1 ops never modify FLAG.
- RESULT/RESULT_REG hold last captured value until next capture.
- Requester dropping REQ before GNT: request withdrawn, no side effect. REQ changes while BUSY are ignored until IDLE.
- Continuous REQ from both: grants strictly alternate 0,1,0,1.
- BUSY = (state != IDLE).

Test Plan:
- Single op: REQ0, OP0=opAdd, A0=1, B0=2, REG_NUM0=5, EXEC_CYCLES=1 -> GNT0 one cycle, DONE0 two cycles later, RESULT=3, RESULT_REG=5, DONE1 never high.
- Tie after reset: REQ0 and REQ1 together -> GNT0 first; both held -> GNT1 next, then GNT0; DONE order 0,1,0.
- Flag ownership: requester-1 op producing ALU_FLAG_OUT=1 -> FLAG stays 0; then requester-0 op producing flag 1 -> FLAG=1, next requester-0 op sees ALU_C_IN=1, requester-1 op sees ALU_C_IN=0.
- Operand stability: EXEC_CYCLES=4, change A0 from 3 to 9 after GNT0 -> ALU_A stays 3 for 4 cycles, RESULT uses 3 (opAdd with B0=2 -> 5), DONE0 at GNT+5.
- Reset mid-operation: RESET_N low during EXEC -> all outputs 0 immediately, no DONE; after release, same REQ0 re-granted and completes normally.
- Withdrawal: REQ1 pulsed low before grant while BUSY with requester 0 -> no GNT1, BUSY drops after DONE0.
